// File: rtl/rbus_pkg.sv
// Shared word layout, flag bit positions and FSM state types for the RBUS
// store-and-forward packet buffer.
package rbus_pkg;

   localparam int WORD_W = 72;
   localparam int LEN_HI = 67;
   localparam int LEN_LO = 64;
   localparam int LEN_W  = LEN_HI - LEN_LO + 1;

   // Bit positions inside i_rdy and i_rdyE
   localparam int RDY_ONE    = 0;
   localparam int RDY_TWO    = 1;
   localparam int RDYE_EMPTY = 0;
   localparam int RDYE_HALF  = 1;

   typedef enum logic {W_IDLE, W_PKT} wstate_t;
   typedef enum logic {R_IDLE, R_PKT} rstate_t;

   function automatic logic [LEN_W-1:0] hdrLen(input logic [WORD_W-1:0] word);
      return word[LEN_HI:LEN_LO];
   endfunction

endpackage

// File: rtl/rbus_fifo_ram.sv
// Simple dual-port word storage for the packet buffer: one write port and
// one read port whose data appears one cycle after the read is issued.
module rbus_fifo_ram
   import rbus_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
)(
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/rbus_pkt_buffer.sv
// Store-and-forward RBUS packet buffer: packets become visible to the reader
// only once their last word has been written and committed.
module rbus_pkt_buffer
   import rbus_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int MAXLEN = 9
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_stb,
   input  logic              i_sof,
   input  logic [WORD_W-1:0] i_data,
   output logic [1:0]        i_rdy,
   output logic [1:0]        i_rdyE,
   output logic              o_stb,
   output logic              o_sof,
   output logic [WORD_W-1:0] o_data,
   input  logic [1:0]        o_rdy,
   input  logic [1:0]        o_rdyE,
   output logic              ff_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0]    FULL_OCC  = PW'(DEPTH);
   localparam logic [LEN_W-1:0] MAXLEN_M1 = LEN_W'(MAXLEN - 1);
   localparam logic [1:0]       RDY_RST   = {DEPTH >= 2 * MAXLEN, DEPTH >= MAXLEN};

   wstate_t          wState_q, wState_d;
   logic [LEN_W-1:0] remain_q, remain_d;
   logic [PW-1:0]    wrPtr_q, wrPtr_d;
   logic [PW-1:0]    cmtPtr_q, cmtPtr_d;
   logic [PW-1:0]    rdPtr_q, rdPtr_d;
   logic             err_q, err_d;
   logic [1:0]       rdy_q, rdyE_q;

   rstate_t          rState_q;
   logic [LEN_W-1:0] rdCnt_q;
   logic             oStb_q, oSof_q;

   logic [LEN_W-1:0]  inLen, rdLeft;
   logic [PW-1:0]     wrBase, occNext;
   logic              baseFull, ramWe, pktAvail, rdIssue;
   logic [WORD_W-1:0] ramRData;
   logic              unusedInputs;

   assign unusedInputs = ^{o_rdy[1], o_rdyE};
   assign inLen = hdrLen(i_data);

   // A header arriving mid-packet restarts writing from the commit point
   assign wrBase   = (wState_q == W_PKT && i_sof) ? cmtPtr_q : wrPtr_q;
   assign baseFull = (wrBase - rdPtr_q) == FULL_OCC;

   always_comb begin
      wState_d = wState_q;
      remain_d = remain_q;
      wrPtr_d  = wrPtr_q;
      cmtPtr_d = cmtPtr_q;
      err_d    = err_q;
      ramWe    = 1'b0;
      if (i_stb) begin
         if (i_sof) begin
            if (wState_q == W_PKT) err_d = 1'b1;
            if (baseFull) begin
               wrPtr_d  = cmtPtr_q;
               wState_d = W_IDLE;
               err_d    = 1'b1;
            end else begin
               ramWe   = 1'b1;
               wrPtr_d = wrBase + PW'(1);
               if (inLen > MAXLEN_M1) err_d = 1'b1;
               if (inLen == '0) begin
                  cmtPtr_d = wrBase + PW'(1);
                  wState_d = W_IDLE;
               end else begin
                  remain_d = inLen;
                  wState_d = W_PKT;
               end
            end
         end else if (wState_q == W_IDLE) begin
            err_d = 1'b1;
         end else if (baseFull) begin
            wrPtr_d  = cmtPtr_q;
            wState_d = W_IDLE;
            err_d    = 1'b1;
         end else begin
            ramWe    = 1'b1;
            wrPtr_d  = wrPtr_q + PW'(1);
            remain_d = remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) begin
               cmtPtr_d = wrPtr_q + PW'(1);
               wState_d = W_IDLE;
            end
         end
      end
   end

   // Header length is taken straight off the RAM output while the header is presented
   assign pktAvail = cmtPtr_q != rdPtr_q;
   assign rdLeft   = oSof_q ? hdrLen(ramRData) : rdCnt_q;
   assign rdIssue  = (rState_q == R_IDLE) ? (pktAvail && o_rdy[0]) : (rdLeft != '0);
   assign rdPtr_d  = rdIssue ? rdPtr_q + PW'(1) : rdPtr_q;
   assign occNext  = wrPtr_d - rdPtr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         wState_q <= W_IDLE;
         remain_q <= '0;
         wrPtr_q  <= '0;
         cmtPtr_q <= '0;
         err_q    <= 1'b0;
         rdy_q    <= RDY_RST;
         rdyE_q   <= 2'b11;
      end else begin
         wState_q <= wState_d;
         remain_q <= remain_d;
         wrPtr_q  <= wrPtr_d;
         cmtPtr_q <= cmtPtr_d;
         err_q    <= err_d;
         rdy_q[RDY_ONE]     <= (DEPTH - int'(occNext)) >= MAXLEN;
         rdy_q[RDY_TWO]     <= (DEPTH - int'(occNext)) >= 2 * MAXLEN;
         rdyE_q[RDYE_EMPTY] <= occNext == '0;
         rdyE_q[RDYE_HALF]  <= int'(occNext) < DEPTH / 2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rState_q <= R_IDLE;
         rdPtr_q  <= '0;
         rdCnt_q  <= '0;
         oStb_q   <= 1'b0;
         oSof_q   <= 1'b0;
      end else begin
         rdPtr_q <= rdPtr_d;
         oStb_q  <= rdIssue;
         oSof_q  <= rdIssue && (rState_q == R_IDLE);
         case (rState_q)
            R_IDLE: if (rdIssue) rState_q <= R_PKT;
            R_PKT: begin
               if (rdIssue) rdCnt_q <= rdLeft - LEN_W'(1);
               else rState_q <= R_IDLE;
            end
            default: rState_q <= R_IDLE;
         endcase
      end
   end

   rbus_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) uRam (
      .clk_i   (clk),
      .we_i    (ramWe),
      .waddr_i (wrBase[AW-1:0]),
      .wdata_i (i_data),
      .re_i    (rdIssue),
      .raddr_i (rdPtr_q[AW-1:0]),
      .rdata_o (ramRData)
   );

   assign o_stb  = oStb_q;
   assign o_sof  = oSof_q;
   assign o_data = oStb_q ? ramRData : '0;
   assign ff_err = err_q;
   assign i_rdy  = rdy_q;
   assign i_rdyE = rdyE_q;

endmodule

// File: tb/tb_rbus_pkt_buffer.sv
// Scoreboard bench for rbus_pkt_buffer: stimulus pushes expected output words,
// an independent monitor pops and compares whenever o_stb is high.
module tb_rbus_pkt_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_stb, i_sof;
   logic [71:0] i_data;
   logic [1:0]  i_rdy, i_rdyE;
   logic        o_stb, o_sof;
   logic [71:0] o_data;
   logic [1:0]  o_rdy, o_rdyE;
   logic        ff_err;

   typedef struct {
      logic        sof;
      logic [71:0] data;
      int          gap;
   } exp_t;

   exp_t expQ[$];
   exp_t expWord;
   int   assertCount = 0;
   int   failCount   = 0;
   int   cycle       = 0;
   int   lastOut     = -100;

   rbus_pkt_buffer #(.DEPTH(32), .MAXLEN(9)) dut (
      .clk    (clk),
      .rst    (rst),
      .i_stb  (i_stb),
      .i_sof  (i_sof),
      .i_data (i_data),
      .i_rdy  (i_rdy),
      .i_rdyE (i_rdyE),
      .o_stb  (o_stb),
      .o_sof  (o_sof),
      .o_data (o_data),
      .o_rdy  (o_rdy),
      .o_rdyE (o_rdyE),
      .ff_err (ff_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor: every presented word must match the head of the scoreboard
   always @(negedge clk) begin
      if (o_stb) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_o_stb", 72'(o_stb), 72'(0));
         end else begin
            expWord = expQ.pop_front();
            checkOutput("o_sof", 72'(o_sof), 72'(expWord.sof));
            checkOutput("o_data", o_data, expWord.data);
            if (expWord.gap >= 0) checkOutput("idle_gap", 72'(cycle - lastOut - 1), 72'(expWord.gap));
         end
         lastOut = cycle;
      end else begin
         checkOutput("o_data_idle", o_data, 72'(0));
      end
   end

   function automatic logic [71:0] mkHdr(input logic [3:0] len, input logic [7:0] tag);
      return {4'hA, len, 8'hE0, 48'h0, tag};
   endfunction

   function automatic logic [71:0] mkPay(input logic [7:0] tag, input logic [7:0] idx);
      return {4'h5, 4'hF, tag, 48'h1234_5678_9ABC, idx};
   endfunction

   task automatic applyStimulus(input logic sof, input logic [71:0] data);
      i_stb  = 1'b1;
      i_sof  = sof;
      i_data = data;
      @(posedge clk);
      #1;
      i_stb  = 1'b0;
      i_sof  = 1'b0;
      i_data = '0;
   endtask

   task automatic sendPacket(input logic [3:0] len, input logic [7:0] tag, input bit expectOut,
                             input int hdrGap, input bit rdyAtLast);
      if (expectOut) begin
         expQ.push_back('{1'b1, mkHdr(len, tag), hdrGap});
         for (int i = 1; i <= int'(len); i++) expQ.push_back('{1'b0, mkPay(tag, 8'(i)), 0});
      end
      if (rdyAtLast && len == 4'd0) o_rdy = 2'b01;
      applyStimulus(1'b1, mkHdr(len, tag));
      for (int i = 1; i <= int'(len); i++) begin
         if (rdyAtLast && i == int'(len)) o_rdy = 2'b01;
         applyStimulus(1'b0, mkPay(tag, 8'(i)));
      end
   endtask

   task automatic doReset();
      rst   = 1'b1;
      i_stb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      expQ.delete();
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((expQ.size() != 0 || o_stb) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain_timeout", 72'(n >= 300), 72'(0));
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst    = 1'b1;
      i_stb  = 1'b0;
      i_sof  = 1'b0;
      i_data = '0;
      o_rdy  = 2'b01;
      o_rdyE = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      checkOutput("rst_o_stb", 72'(o_stb), 72'(0));
      checkOutput("rst_o_sof", 72'(o_sof), 72'(0));
      checkOutput("rst_o_data", o_data, 72'(0));
      checkOutput("rst_ff_err", 72'(ff_err), 72'(0));
      checkOutput("rst_i_rdy", 72'(i_rdy), 72'(2'b11));
      checkOutput("rst_i_rdyE", 72'(i_rdyE), 72'(2'b11));

      // Single LEN=3 packet: header two cycles after the last word
      sendPacket(4'd3, 8'h01, 1'b1, -1, 1'b0);
      checkOutput("i_rdyE_after_write", 72'(i_rdyE), 72'(2'b10));
      checkOutput("not_early_sof", 72'(o_sof), 72'(0));
      @(posedge clk);
      #1;
      checkOutput("latency_T+2_sof", 72'(o_sof), 72'(1));
      waitDrain();
      checkOutput("i_rdyE_drained", 72'(i_rdyE), 72'(2'b11));

      // Three 9-word packets held back, then released in order
      o_rdy = 2'b00;
      sendPacket(4'd8, 8'h11, 1'b1, -1, 1'b0);
      checkOutput("i_rdy_occ9", 72'(i_rdy), 72'(2'b11));
      sendPacket(4'd8, 8'h12, 1'b1, 1, 1'b0);
      checkOutput("i_rdy_occ18", 72'(i_rdy), 72'(2'b01));
      sendPacket(4'd8, 8'h13, 1'b1, 1, 1'b0);
      checkOutput("i_rdy_occ27", 72'(i_rdy), 72'(2'b00));
      checkOutput("i_rdyE_occ27", 72'(i_rdyE), 72'(2'b00));
      repeat (4) @(posedge clk);
      #1;
      checkOutput("held_no_output", 72'(o_stb), 72'(0));
      o_rdy = 2'b01;
      waitDrain();
      checkOutput("i_rdy_drained", 72'(i_rdy), 72'(2'b11));

      // Commit of B coincides with read start of A
      o_rdy = 2'b00;
      sendPacket(4'd2, 8'h21, 1'b1, -1, 1'b0);
      sendPacket(4'd1, 8'h22, 1'b1, 1, 1'b1);
      checkOutput("A_header_immediate", 72'(o_sof), 72'(1));
      waitDrain();

      // Header interrupting a partial packet
      checkOutput("err_clear_before", 72'(ff_err), 72'(0));
      applyStimulus(1'b1, mkHdr(4'd4, 8'h31));
      applyStimulus(1'b0, mkPay(8'h31, 8'd1));
      applyStimulus(1'b0, mkPay(8'h31, 8'd2));
      sendPacket(4'd0, 8'h32, 1'b1, -1, 1'b0);
      checkOutput("err_interrupted_pkt", 72'(ff_err), 72'(1));
      waitDrain();

      // Stray payload word while idle
      doReset();
      checkOutput("err_cleared_by_rst", 72'(ff_err), 72'(0));
      applyStimulus(1'b0, mkPay(8'h41, 8'd1));
      checkOutput("err_stray_payload", 72'(ff_err), 72'(1));
      repeat (5) @(posedge clk);
      #1;
      checkOutput("stray_i_rdyE", 72'(i_rdyE), 72'(2'b11));

      // Buffer exactly full, overflowing packet dropped
      doReset();
      o_rdy = 2'b00;
      sendPacket(4'd8, 8'h51, 1'b1, -1, 1'b0);
      sendPacket(4'd8, 8'h52, 1'b1, 1, 1'b0);
      sendPacket(4'd8, 8'h53, 1'b1, 1, 1'b0);
      sendPacket(4'd4, 8'h54, 1'b1, 1, 1'b0);
      checkOutput("full_i_rdy", 72'(i_rdy), 72'(2'b00));
      checkOutput("full_i_rdyE", 72'(i_rdyE), 72'(2'b00));
      checkOutput("full_err_before", 72'(ff_err), 72'(0));
      sendPacket(4'd8, 8'h55, 1'b0, -1, 1'b0);
      checkOutput("overflow_err", 72'(ff_err), 72'(1));
      o_rdy = 2'b01;
      waitDrain();
      checkOutput("overflow_drained_i_rdyE", 72'(i_rdyE), 72'(2'b11));

      // Reset during the second payload word of an outgoing packet
      sendPacket(4'd5, 8'h61, 1'b1, -1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      expQ.delete();
      checkOutput("trunc_o_stb", 72'(o_stb), 72'(0));
      checkOutput("trunc_i_rdy", 72'(i_rdy), 72'(2'b11));
      checkOutput("trunc_i_rdyE", 72'(i_rdyE), 72'(2'b11));
      checkOutput("trunc_ff_err", 72'(ff_err), 72'(0));
      repeat (10) @(posedge clk);
      #1;

      // Over-long header: flagged but still forwarded in full
      sendPacket(4'd9, 8'h71, 1'b1, -1, 1'b0);
      checkOutput("overlong_err", 72'(ff_err), 72'(1));
      waitDrain();

      checkOutput("leftover_expected", 72'(expQ.size()), 72'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/rbus_pkt_buffer.md
RBUS_PKT_BUFFER -- requirements
Module: rbus_pkt_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32: buffer capacity in 72-bit words; power of two, at least 18.
REQ-002 The block SHALL have parameter MAXLEN, default 9: maximum packet length in words, header included.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port i_stb, input, 1 bit: input word valid.
REQ-006 The block SHALL have port i_sof, input, 1 bit: input word is a packet header.
REQ-007 The block SHALL have port i_data, input, 72 bits: input word; header field LEN = i_data[67:64] gives the payload word count, 0..MAXLEN-1.
REQ-008 The block SHALL have port i_rdy, output, 2 bits: bit0 = free space >= MAXLEN words; bit1 = free space >= 2*MAXLEN words.
REQ-009 The block SHALL have port i_rdyE, output, 2 bits: bit0 = buffer empty; bit1 = occupancy < DEPTH/2.
REQ-010 The block SHALL have port o_stb, output, 1 bit: output word valid.
REQ-011 The block SHALL have port o_sof, output, 1 bit: output word is a header.
REQ-012 The block SHALL have port o_data, output, 72 bits: output word.
REQ-013 The block SHALL have port o_rdy, input, 2 bits: downstream ready; only bit0 is used, and it gates packet start.
REQ-014 The block SHALL have port o_rdyE, input, 2 bits: accepted and ignored.
REQ-015 The block SHALL have port ff_err, output, 1 bit: sticky protocol or overflow error.

Function
REQ-016 The block SHALL operate store-and-forward: a packet becomes readable only after its last word is written (commit).
REQ-017 The write FSM SHALL have states W_IDLE and W_PKT, with a remaining-word counter (4 bits).
REQ-018 In W_IDLE, i_stb&i_sof SHALL write the header, load remaining = LEN, and go to W_PKT; if LEN=0, the packet SHALL commit in that cycle and the FSM SHALL stay in W_IDLE.
REQ-019 In W_PKT, each i_stb&!i_sof SHALL write a word and decrement remaining; when remaining reaches 0, the packet SHALL commit and the FSM SHALL go to W_IDLE.
REQ-020 Commit SHALL copy the write pointer into the commit pointer.
REQ-021 i_stb&!i_sof in W_IDLE SHALL drop the word and set ff_err.
REQ-022 i_stb&i_sof in W_PKT SHALL rewind the write pointer to the commit pointer (discarding the partial packet), set ff_err, and start a new packet with this header.
REQ-023 A write while the buffer is full SHALL drop the word, rewind the write pointer to the commit pointer, set ff_err, and return to W_IDLE; the remaining words of that packet SHALL then be dropped under REQ-021.
REQ-024 LEN > MAXLEN-1 SHALL set ff_err; the packet SHALL still be accepted as given.
REQ-025 The read FSM SHALL have states R_IDLE and R_PKT.
REQ-026 In R_IDLE, when at least one committed packet exists and o_rdy[0]=1, the block SHALL issue a read of the header; o_stb=1 and o_sof=1 SHALL appear in the next cycle.
REQ-027 In R_PKT, the block SHALL emit all LEN payload words on consecutive cycles with o_stb=1 and o_sof=0, without regard to o_rdy, then return to R_IDLE.
REQ-028 The earliest next header after a packet's last payload word SHALL be one idle cycle later.
REQ-029 Latency: if the last input word is accepted in cycle T and o_rdy[0]=1, o_sof SHALL be high in cycle T+2.
REQ-030 A commit and a read start in the same cycle SHALL both take effect; the packet being committed SHALL not be readable until the next cycle.
REQ-031 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-032 Occupancy SHALL equal the write pointer minus the read pointer; full SHALL mean occupancy = DEPTH.
REQ-033 i_rdy and i_rdyE SHALL be registered and SHALL use the write pointer (not the commit pointer), so they are conservative.
REQ-034 When o_stb=0, o_data SHALL be 0.
REQ-035 ff_err SHALL be sticky until rst.

Reset
REQ-036 rst SHALL clear all pointers and return both FSMs to their IDLE states.
REQ-037 After rst, o_stb=0, o_sof=0, o_data=0, ff_err=0, i_rdy=2'b11, i_rdyE=2'b11 (default parameters).
REQ-038 rst during output of a packet SHALL truncate it: o_stb=0 from the next cycle; there SHALL be no resume.
REQ-039 rst during input of a packet SHALL discard it.

Structure
REQ-040 Package rbus_pkg SHALL hold the word width (72), the LEN field position (67:64), and the rdy/rdyE bit-index constants.
REQ-041 Storage SHALL be a single sub-module, rbus_fifo_ram: simple dual-port, DEPTH x 72, one-cycle registered read.
REQ-042 Both FSMs, the pointers, and the flags SHALL reside in rbus_pkt_buffer.

Verification
REQ-043 After reset, write one packet (header LEN=3, 3 payload words) with o_rdy=01 -> o_sof at T+2, then 3 payload words with identical data; i_rdyE returns to 11.
REQ-044 Write 3 packets of 9 words with o_rdy=00 -> i_rdy goes 11 -> 01 -> 00 (free space 5 < 9); nothing is output; then o_rdy=01 -> packets are output in order with 1 idle cycle between them.
REQ-045 Header with LEN=4, 2 payload words, then a new header with LEN=0 -> ff_err=1; only the LEN=0 packet is output.
REQ-046 With the buffer held full (o_rdy=00), write a 9-word packet -> ff_err=1; occupancy is unchanged; previously committed packets are output intact.
REQ-047 Assert rst for 1 cycle during the 2nd payload word of an outgoing LEN=5 packet -> o_stb=0 the next cycle, i_rdy=11, and ff_err=0.
REQ-048 A commit of packet B in the same cycle a read of packet A starts -> A is output immediately and B's header follows A's last word after exactly 1 idle cycle.
